// File: rtl/reg_exec_ctrl_pkg.sv
// Shared types and instruction layout for the register-execute controller.
// Holds the opcode/state enums, instruction field positions and width defaults.
package reg_exec_ctrl_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 3;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 13;
   localparam int RD_MSB  = 12;
   localparam int RD_LSB  = 10;
   localparam int RS1_MSB = 9;
   localparam int RS1_LSB = 7;
   localparam int RS2_MSB = 6;
   localparam int RS2_LSB = 4;
   localparam int IMM_MSB = 3;
   localparam int IMM_LSB = 0;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_OR   = 3'b011,
      OP_XOR  = 3'b100,
      OP_SLT  = 3'b101,
      OP_ADDI = 3'b110,
      OP_NOP  = 3'b111
   } opcode_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      READ = 2'b01,
      EXEC = 2'b10,
      WB   = 2'b11
   } state_e;

   function automatic opcode_e get_opcode(input logic [15:0] word);
      return opcode_e'(word[OP_MSB:OP_LSB]);
   endfunction

endpackage

// File: rtl/reg_exec_ctrl_alu8.sv
// Combinational ALU for the register-execute controller.
// Carry is the MSB carry-out for ADD/ADDI and the borrow for SUB.
module alu8
   import reg_exec_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  opcode_e           opcode,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [3:0]        imm,
   output logic [DATA_W-1:0] result,
   output logic              carry
);

   logic [DATA_W:0] sum_s;

   // Operation select; NOP and unused codes yield zero with no carry.
   always_comb begin
      sum_s  = '0;
      result = '0;
      carry  = 1'b0;
      case (opcode)
         OP_ADD: begin
            sum_s  = {1'b0, a} + {1'b0, b};
            result = sum_s[DATA_W-1:0];
            carry  = sum_s[DATA_W];
         end
         OP_SUB: begin
            result = a - b;
            carry  = (a < b);
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_SLT:  result = (a < b) ? DATA_W'(1) : '0;
         OP_ADDI: begin
            sum_s  = {1'b0, a} + (DATA_W + 1)'(imm);
            result = sum_s[DATA_W-1:0];
            carry  = sum_s[DATA_W];
         end
         OP_NOP:  result = '0;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/reg_exec_ctrl.sv
// Four-state instruction controller: accept, read operands, execute, write back.
// No forwarding; the idle cycle after write-back covers register file latency.
module reg_exec_ctrl
   import reg_exec_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   input  logic [15:0]       instr,
   output logic              instr_ready,
   output logic [ADDR_W-1:0] ra1,
   output logic [ADDR_W-1:0] ra2,
   input  logic [DATA_W-1:0] rd1,
   input  logic [DATA_W-1:0] rd2,
   output logic              we3,
   output logic [ADDR_W-1:0] wa3,
   output logic [DATA_W-1:0] wd3,
   output logic              done,
   output logic              zero,
   output logic              carry
);

   state_e            state_r, next_s;
   opcode_e           op_r;
   logic [2:0]        rd_r;
   logic [3:0]        imm_r;
   logic [DATA_W-1:0] op_a_r, op_b_r, result_r;
   logic [DATA_W-1:0] alu_result_s;
   logic              alu_carry_s;
   logic [ADDR_W-1:0] ra1_r, ra2_r, wa3_r;
   logic              we3_r, done_r, zero_r, carry_r;
   logic              accept_s;

   assign accept_s    = instr_valid && (state_r == IDLE);
   assign instr_ready = (state_r == IDLE);
   assign ra1         = ra1_r;
   assign ra2         = ra2_r;
   assign we3         = we3_r;
   assign wa3         = wa3_r;
   assign wd3         = result_r;
   assign done        = done_r;
   assign zero        = zero_r;
   assign carry       = carry_r;

   alu8 #(.DATA_W(DATA_W)) u_alu (
      .opcode (op_r),
      .a      (op_a_r),
      .b      (op_b_r),
      .imm    (imm_r),
      .result (alu_result_s),
      .carry  (alu_carry_s)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Next-state logic; every non-idle state advances unconditionally.
   always_comb begin
      next_s = state_r;
      case (state_r)
         IDLE: begin
            if (instr_valid) begin
               next_s = READ;
            end else begin
               next_s = IDLE;
            end
         end
         READ:    next_s = EXEC;
         EXEC:    next_s = WB;
         WB:      next_s = IDLE;
         default: next_s = IDLE;
      endcase
   end

   // Datapath and output registers; done/we3 are set on the EXEC->WB edge only.
   always_ff @(posedge clk) begin
      if (!rst) begin
         op_r     <= OP_ADD;
         rd_r     <= 3'd0;
         imm_r    <= 4'd0;
         ra1_r    <= '0;
         ra2_r    <= '0;
         op_a_r   <= '0;
         op_b_r   <= '0;
         result_r <= '0;
         wa3_r    <= '0;
         we3_r    <= 1'b0;
         done_r   <= 1'b0;
         zero_r   <= 1'b0;
         carry_r  <= 1'b0;
      end else begin
         we3_r  <= 1'b0;
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  op_r  <= get_opcode(instr);
                  rd_r  <= instr[RD_MSB:RD_LSB];
                  imm_r <= instr[IMM_MSB:IMM_LSB];
                  ra1_r <= ADDR_W'(instr[RS1_MSB:RS1_LSB]);
                  ra2_r <= ADDR_W'(instr[RS2_MSB:RS2_LSB]);
               end
            end
            READ: begin
               op_a_r <= rd1;
               op_b_r <= rd2;
            end
            EXEC: begin
               result_r <= alu_result_s;
               zero_r   <= (alu_result_s == '0);
               carry_r  <= alu_carry_s;
               wa3_r    <= ADDR_W'(rd_r);
               done_r   <= 1'b1;
               we3_r    <= (op_r != OP_NOP) && (rd_r != 3'd0);
            end
            WB:      ;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/reg_exec_ctrl.md
REG_EXEC_CTRL -- requirements
Module: reg_exec_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, register data width.
REQ-002 SHALL have parameter ADDR_W, default 3, register address width.
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port instr_valid  input  1  instruction offered.
REQ-006 SHALL have port instr  input  16  instruction word.
REQ-007 SHALL have port instr_ready  output  1  controller can accept an instruction.
REQ-008 SHALL have ports ra1, ra2  output  ADDR_W  register file read addresses.
REQ-009 SHALL have ports rd1, rd2  input  DATA_W  register file read data, combinational from ra1/ra2.
REQ-010 SHALL have ports we3 (output, 1), wa3 (output, ADDR_W) and wd3 (output, DATA_W): register file write enable, address and data.
REQ-011 SHALL have port done  output  1  one-cycle pulse when an instruction retires.
REQ-012 SHALL have ports zero and carry  output  1 each  flags of the last executed instruction.

Function
REQ-013 SHALL decode instr as opcode[15:13], rd[12:10], rs1[9:7], rs2[6:4], imm[3:0].
REQ-014 SHALL implement these opcodes:
- 000 ADD
- 001 SUB (rs1-rs2)
- 010 AND
- 011 OR
- 100 XOR
- 101 SLT (unsigned; result 1 if rs1<rs2, else 0)
- 110 ADDI (rs1 + zero-extended imm)
- 111 NOP
REQ-015 SHALL implement FSM states IDLE, READ, EXEC, WB.
REQ-016 In IDLE, instr_ready SHALL be 1; it SHALL be 0 in all other states.
REQ-017 SHALL latch instr and move IDLE->READ on an edge where instr_valid&&instr_ready; otherwise it SHALL stay in IDLE.
REQ-018 In READ, SHALL drive ra1=rs1 and ra2=rs2, capture rd1/rd2 into operand registers at cycle end, then go to EXEC.
REQ-019 ra1/ra2 SHALL hold the last latched fields in all states.
REQ-020 In EXEC, SHALL compute the result modulo 2^DATA_W, register result/zero/carry, then go to WB.
REQ-021 zero SHALL be (result==0).
REQ-022 carry SHALL be the bit-7 carry-out for ADD/ADDI, the borrow (rs1<rs2) for SUB, and 0 otherwise.
REQ-023 In WB, done SHALL be 1, wa3=rd and wd3=result, then the FSM SHALL return unconditionally to IDLE.
REQ-024 In WB, we3 SHALL be 1 only if opcode!=NOP and rd!=0; we3 SHALL be 0 in all other states.
REQ-025 Latency SHALL be fixed: done is high in the 3rd cycle after the acceptance edge; throughput is one instruction per 4 cycles.
REQ-026 The mandatory IDLE cycle after WB SHALL cover the register file's 2-edge write-to-read latency; no forwarding SHALL be implemented.
REQ-027 instr changes while not in IDLE SHALL have no effect.
REQ-028 zero/carry SHALL hold until the next EXEC; wa3/wd3 SHALL hold until the next WB.

Reset
REQ-029 When rst=0 at an edge, SHALL enter IDLE and clear: latched instr, operands, result, ra1, ra2, wa3, wd3, we3, done, zero, carry.
REQ-030 Reset mid-operation (READ/EXEC/WB) SHALL abort the instruction with no write and no done pulse.
REQ-031 instr_ready SHALL be 1 on the first cycle after rst returns to 1.

Structure
REQ-032 A shared package SHALL hold the opcode enum, state enum, instruction field positions and DATA_W/ADDR_W defaults.
REQ-033 The arithmetic SHALL be a combinational sub-module alu8 (opcode, a, b, imm -> result, carry); the FSM and registers SHALL stay in reg_exec_ctrl.

Verification
REQ-034 After reset, ADDI x1,x0,5 with rd1=0 -> we3=1, wa3=1, wd3=5, done 3 cycles after accept, zero=0.
REQ-035 With x1=200 and x2=100, ADD x3,x1,x2 -> wd3=44, carry=1; then SUB x4,x2,x1 -> wd3=156, carry=1.
REQ-036 ADD x0,x1,x2 and NOP -> done pulses, we3 stays 0 both times.
REQ-037 instr_valid held high continuously -> instr_ready high only 1 of every 4 cycles, exactly one accept per 4 cycles.
REQ-038 rst=0 asserted during EXEC -> no we3, no done, all outputs 0, instr_ready=1 one cycle after release.
REQ-039 XOR x5,x1,x1 -> wd3=0, zero=1, carry=0; the bench SHALL check the back-to-back dependent read via a connected 8-entry register file model.
